// File: rtl/game_sequencer_if.sv
// Game-control bundle between the sequencer and the rest of the game:
// raw buttons and playfield events in, physics/scroll controls and scores out.
interface game_sequencer_if;
    logic       start_btn;
    logic       flap_btn;
    logic       collision;
    logic       pipe_passed;
    logic       frame_tick;
    logic       phys_reset;
    logic       phys_en;
    logic       flap_req;
    logic       scroll_en;
    logic [7:0] score;
    logic [7:0] high_score;
    logic [1:0] state;

    // Environment side: drives buttons and playfield events, observes controls.
    modport master (
        output start_btn, flap_btn, collision, pipe_passed,
        input  frame_tick, phys_reset, phys_en, flap_req, scroll_en,
               score, high_score, state
    );

    // Sequencer side.
    modport slave (
        input  start_btn, flap_btn, collision, pipe_passed,
        output frame_tick, phys_reset, phys_en, flap_req, scroll_en,
               score, high_score, state
    );
endinterface

// File: rtl/game_sequencer.sv
// Game sequencer: frame-rate strobe, button conditioning, the
// IDLE/PLAY/DYING/OVER flow, score keeping and the best score since reset.
module game_sequencer #(
    parameter int unsigned FRAME_DIV    = 833334,  // clk cycles per frame tick, >= 2
    parameter int unsigned DEATH_FRAMES = 30       // frame ticks spent dying, >= 1
) (
    input  logic             clk,
    input  logic             reset,      // asynchronous, active low
    game_sequencer_if.slave  bus
);

    localparam int unsigned CNT_W   = $clog2(FRAME_DIV);
    localparam int unsigned DTH_W   = $clog2(DEATH_FRAMES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);
    localparam logic [DTH_W-1:0] DTH_LAST = DTH_W'(DEATH_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t           state_q, state_next;
    logic [CNT_W-1:0] frame_cnt;
    logic [DTH_W-1:0] death_cnt, death_next;
    logic [7:0]       score_q, score_next;
    logic [7:0]       high_q, high_next;
    logic             flap_pend, flap_pend_next;
    logic             phys_reset_q, phys_en_q, scroll_en_q;

    // Button conditioning: bit 0 = start, bit 1 = flap.
    logic [1:0] btn_meta, btn_sync, btn_prev, btn_edge;
    logic       start_edge, flap_edge;
    logic       frame_tick;

    assign start_edge = btn_edge[0];
    assign flap_edge  = btn_edge[1];
    assign frame_tick = (frame_cnt == CNT_LAST);

    // Free-running frame divider, active in every state.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (frame_tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // Two-flop synchronizers followed by a registered rising-edge detector,
    // giving a one-cycle pulse three cycles after the button goes high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_meta <= '0;
            btn_sync <= '0;
            btn_prev <= '0;
            btn_edge <= '0;
        end else begin
            btn_meta <= {bus.flap_btn, bus.start_btn};
            btn_sync <= btn_meta;
            btn_prev <= btn_sync;
            btn_edge <= btn_sync & ~btn_prev;
        end
    end

    // Next-state and datapath decode for the game flow.
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next     = state_q;
        death_next     = '0;
        score_next     = score_q;
        high_next      = high_q;
        flap_pend_next = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge || flap_edge) state_next = ST_PLAY;
            end
            ST_PLAY: begin
                // Collision only counts on the physics update strobe.
                if (frame_tick && bus.collision) state_next = ST_DYING;
            end
            ST_DYING: begin
                if (frame_tick && (death_cnt == DTH_LAST)) state_next = ST_OVER;
            end
            ST_OVER: begin
                if (start_edge) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // Death counter only lives while staying in DYING.
        if (state_q == ST_DYING && state_next == ST_DYING && frame_tick) begin
            death_next = death_cnt + DTH_W'(1);
        end else if (state_q == ST_DYING && state_next == ST_DYING) begin
            death_next = death_cnt;
        end

        // Score clears whenever the game is (re)entering IDLE; pipes count
        // in PLAY, including on the cycle a collision is seen.
        if (state_next == ST_IDLE) begin
            score_next = '0;
        end else if (state_q == ST_PLAY && bus.pipe_passed && score_q != 8'hFF) begin
            score_next = score_q + 8'd1;
        end

        if (state_q == ST_DYING && state_next == ST_OVER && score_q > high_q) begin
            high_next = score_q;
        end

        // One pending flap per frame; an edge on the tick cycle carries into
        // the next frame. Anything outside a continuing PLAY drops it.
        if (state_q == ST_PLAY && state_next == ST_PLAY) begin
            flap_pend_next = frame_tick ? flap_edge : (flap_pend | flap_edge);
        end
    end

    // Game state, counters, scores and registered control outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            death_cnt    <= '0;
            score_q      <= '0;
            high_q       <= '0;
            flap_pend    <= 1'b0;
            phys_reset_q <= 1'b1;
            phys_en_q    <= 1'b0;
            scroll_en_q  <= 1'b0;
        end else begin
            state_q      <= state_next;
            death_cnt    <= death_next;
            score_q      <= score_next;
            high_q       <= high_next;
            flap_pend    <= flap_pend_next;
            phys_reset_q <= (state_next == ST_IDLE);
            phys_en_q    <= (state_next == ST_PLAY) || (state_next == ST_DYING);
            scroll_en_q  <= (state_next == ST_PLAY);
        end
    end

    assign bus.frame_tick = frame_tick;
    assign bus.flap_req   = frame_tick & flap_pend;
    assign bus.phys_reset = phys_reset_q;
    assign bus.phys_en    = phys_en_q;
    assign bus.scroll_en  = scroll_en_q;
    assign bus.score      = score_q;
    assign bus.high_score = high_q;
    assign bus.state      = state_q;

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 Parameter FRAME_DIV, default 833334: clk cycles per frame tick (60 Hz at 50 MHz); legal values >= 2.
REQ-002 Parameter DEATH_FRAMES, default 30: frame ticks spent in DYING before OVER; legal values >= 1.
REQ-003 Port clk  in  1  single system clock; all logic SHALL be clocked on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset (0 = in reset).
REQ-005 Port start_btn  in  1  raw start button level, asynchronous to clk.
REQ-006 Port flap_btn  in  1  raw flap button level, asynchronous to clk.
REQ-007 Port collision  in  1  level from the collision checker; 1 = bird overlaps a pipe or a screen edge.
REQ-008 Port pipe_passed  in  1  one-cycle pulse, one per pipe cleared.
REQ-009 Port frame_tick  out  1  one-cycle physics/scroll update strobe.
REQ-010 Port phys_reset  out  1  holds the bird physics at its start position.
REQ-011 Port phys_en  out  1  enables the physics update on frame_tick.
REQ-012 Port flap_req  out  1  one-cycle flap command, coincident with frame_tick.
REQ-013 Port scroll_en  out  1  enables pipe scrolling.
REQ-014 Port score  out  8  current score, binary.
REQ-015 Port high_score  out  8  best score since reset.
REQ-016 Port state  out  2  game state: IDLE=0, PLAY=1, DYING=2, OVER=3.

Function
REQ-017 Frame counter: counts 0..FRAME_DIV-1 and wraps; runs in every state; frame_tick=1 exactly in the cycle where the count equals FRAME_DIV-1.
REQ-018 Each button SHALL pass through a 2-flop synchronizer; a rising edge is detected on the synchronized value; edge pulse latency SHALL be 3 cycles from the button going high.
REQ-019 A flap edge in PLAY SHALL set flap_pend; flap_pend clears on the next frame_tick, and flap_req=1 in that same cycle; multiple edges within one frame SHALL yield one flap_req.
REQ-020 flap_pend SHALL be cleared and flap_req held 0 in every state other than PLAY.
REQ-021 IDLE: phys_reset=1, phys_en=0, scroll_en=0, score=0; a start edge or a flap edge SHALL move to PLAY on the next cycle; a flap edge that starts the game SHALL NOT set flap_pend.
REQ-022 PLAY: phys_reset=0, phys_en=1, scroll_en=1; each pipe_passed pulse increments score, saturating at 255.
REQ-023 PLAY: collision is sampled only on frame_tick; collision=1 at frame_tick SHALL move to DYING on the next cycle.
REQ-024 A pipe_passed pulse in the same cycle as a collision frame_tick SHALL still increment score.
REQ-025 DYING: phys_en=1, scroll_en=0, flap_req=0; a death counter counts frame ticks from 0; state SHALL move to OVER on the cycle after the DEATH_FRAMES-th frame_tick.
REQ-026 On entry to OVER: high_score <= score if score > high_score; phys_en=0, scroll_en=0, score held.
REQ-027 OVER: a start edge SHALL move to IDLE; flap edges are ignored.
REQ-028 pipe_passed outside PLAY SHALL be ignored; collision outside PLAY SHALL be ignored.
REQ-029 All outputs SHALL be registered, except frame_tick and flap_req, which may be decoded from registers in the same cycle.

Reset
REQ-030 While reset=0: state=IDLE, frame counter=0, death counter=0, score=0, high_score=0, flap_pend=0, synchronizers=0, phys_reset=1, all other outputs 0.
REQ-031 Reset asserted mid-game SHALL take effect immediately (asynchronous); high_score SHALL also clear.
REQ-032 After reset deasserts, the first frame_tick SHALL occur FRAME_DIV cycles later.

Verification (FRAME_DIV=4, DEATH_FRAMES=3)
REQ-033 Release reset -> frame_tick on cycles 4, 8, 12...; state=0; phys_reset=1.
REQ-034 Start edge -> state=1 three cycles after btn high + 1; phys_en=1; scroll_en=1; score=0.
REQ-035 In PLAY, 3 flap edges within one frame -> exactly one flap_req, on the next frame_tick; a flap edge after that tick -> flap_req on the following tick.
REQ-036 260 pipe_passed pulses in PLAY -> score=255; pipe_passed + collision on the same tick -> score increments and state=2.
REQ-037 DYING -> state=3 one cycle after the 3rd subsequent frame_tick; high_score=score; start edge -> state=0, score=0, high_score retained.
REQ-038 Reset low while in DYING -> all outputs at REQ-030 values in the same cycle, high_score=0.
